// File: rtl/axis_move_dispatcher.sv
`timescale 1ns/1ps
// Fans one coordinated XYZE move out to the four axis step generators and
// tracks per-axis completion, with move timeout and abort handling.
module axis_move_dispatcher #(
  parameter int unsigned       STEP_W     = 16,
  parameter int unsigned       TMO_W      = 24,
  parameter logic [TMO_W-1:0]  TMO_CYCLES = 24'd10_000_000
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_CmdValid,
  output logic              o_CmdReady,
  input  logic [STEP_W-1:0] i_StepsX,
  input  logic [STEP_W-1:0] i_StepsY,
  input  logic [STEP_W-1:0] i_StepsZ,
  input  logic [STEP_W-1:0] i_StepsE,
  input  logic [3:0]        i_Dir,
  output logic [STEP_W-1:0] o_StepsX,
  output logic [STEP_W-1:0] o_StepsY,
  output logic [STEP_W-1:0] o_StepsZ,
  output logic [STEP_W-1:0] o_StepsE,
  output logic [3:0]        o_Dir,
  output logic [3:0]        o_Start,
  input  logic [3:0]        i_AxisDone,
  input  logic              i_Abort,
  output logic              o_AxisAbort,
  output logic              o_Busy,
  output logic              o_MoveDone,
  output logic              o_Fault,
  input  logic              i_ClearFault
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_FAULT
  } state_t;

  localparam bit               TMO_EN   = (TMO_CYCLES != '0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_CYCLES - 1'b1;

  state_t              state_q, state_d;
  logic [3:0]          pending_q, pending_d;
  logic [STEP_W-1:0]   steps_x_q, steps_x_d;
  logic [STEP_W-1:0]   steps_y_q, steps_y_d;
  logic [STEP_W-1:0]   steps_z_q, steps_z_d;
  logic [STEP_W-1:0]   steps_e_q, steps_e_d;
  logic [3:0]          dir_q, dir_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic                move_done_q, move_done_d;
  logic                axis_abort_q, axis_abort_d;
  logic                launch_done;

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    steps_x_d    = steps_x_q;
    steps_y_d    = steps_y_q;
    steps_z_d    = steps_z_q;
    steps_e_d    = steps_e_q;
    dir_d        = dir_q;
    tmo_cnt_d    = tmo_cnt_q;
    move_done_d  = 1'b0;
    axis_abort_d = 1'b0;
    launch_done  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_CmdValid) begin
          steps_x_d = i_StepsX;
          steps_y_d = i_StepsY;
          steps_z_d = i_StepsZ;
          steps_e_d = i_StepsE;
          dir_d     = i_Dir;
          pending_d = {i_StepsE != '0, i_StepsZ != '0,
                       i_StepsY != '0, i_StepsX != '0};
          state_d   = ST_LAUNCH;
        end
      end

      ST_LAUNCH: begin
        tmo_cnt_d = '0;
        pending_d = pending_q & ~i_AxisDone;
        if (i_Abort) begin
          pending_d    = '0;
          axis_abort_d = 1'b1;
          state_d      = ST_IDLE;
        end else if (pending_q == '0) begin
          // Empty move completes in the launch cycle itself.
          launch_done = 1'b1;
          state_d     = ST_IDLE;
        end else if (pending_d == '0) begin
          move_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        pending_d = pending_q & ~i_AxisDone;
        // Priority: abort, then completion, then timeout expiry.
        if (i_Abort) begin
          pending_d    = '0;
          axis_abort_d = 1'b1;
          state_d      = ST_IDLE;
        end else if (pending_d == '0) begin
          move_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (TMO_EN && (tmo_cnt_q == TMO_LAST)) begin
          pending_d    = '0;
          axis_abort_d = 1'b1;
          state_d      = ST_FAULT;
        end
      end

      ST_FAULT: begin
        if (i_ClearFault) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      steps_x_q    <= '0;
      steps_y_q    <= '0;
      steps_z_q    <= '0;
      steps_e_q    <= '0;
      dir_q        <= '0;
      tmo_cnt_q    <= '0;
      move_done_q  <= 1'b0;
      axis_abort_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      steps_x_q    <= steps_x_d;
      steps_y_q    <= steps_y_d;
      steps_z_q    <= steps_z_d;
      steps_e_q    <= steps_e_d;
      dir_q        <= dir_d;
      tmo_cnt_q    <= tmo_cnt_d;
      move_done_q  <= move_done_d;
      axis_abort_q <= axis_abort_d;
    end
  end

  assign o_CmdReady  = (state_q == ST_IDLE);
  assign o_Busy      = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);
  assign o_Fault     = (state_q == ST_FAULT);
  assign o_Start     = (state_q == ST_LAUNCH) ? pending_q : 4'b0000;
  assign o_MoveDone  = move_done_q | launch_done;
  assign o_AxisAbort = axis_abort_q;
  assign o_StepsX    = steps_x_q;
  assign o_StepsY    = steps_y_q;
  assign o_StepsZ    = steps_z_q;
  assign o_StepsE    = steps_e_q;
  assign o_Dir       = dir_q;

endmodule

// File: tb/tb_axis_move_dispatcher.sv
`timescale 1ns/1ps
// Scoreboard bench for axis_move_dispatcher: start/done/abort pulses are
// predicted with their cycle numbers and matched as the DUT emits them.
module tb_axis_move_dispatcher;

  localparam int unsigned STEP_W = 16;
  localparam int EV_START = 1;
  localparam int EV_DONE  = 2;
  localparam int EV_ABORT = 3;

  logic              clk = 1'b0;
  logic              i_Reset = 1'b1;
  logic              i_CmdValid = 1'b0;
  logic              o_CmdReady;
  logic [STEP_W-1:0] i_StepsX = '0, i_StepsY = '0, i_StepsZ = '0, i_StepsE = '0;
  logic [3:0]        i_Dir = '0;
  logic [STEP_W-1:0] o_StepsX, o_StepsY, o_StepsZ, o_StepsE;
  logic [3:0]        o_Dir, o_Start;
  logic [3:0]        i_AxisDone = '0;
  logic              i_Abort = 1'b0;
  logic              o_AxisAbort, o_Busy, o_MoveDone, o_Fault;
  logic              i_ClearFault = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [63:0] exp_q[$];

  axis_move_dispatcher #(
    .STEP_W    (STEP_W),
    .TMO_W     (24),
    .TMO_CYCLES(24'd16)
  ) dut (
    .i_Clk       (clk),
    .i_Reset     (i_Reset),
    .i_CmdValid  (i_CmdValid),
    .o_CmdReady  (o_CmdReady),
    .i_StepsX    (i_StepsX),
    .i_StepsY    (i_StepsY),
    .i_StepsZ    (i_StepsZ),
    .i_StepsE    (i_StepsE),
    .i_Dir       (i_Dir),
    .o_StepsX    (o_StepsX),
    .o_StepsY    (o_StepsY),
    .o_StepsZ    (o_StepsZ),
    .o_StepsE    (o_StepsE),
    .o_Dir       (o_Dir),
    .o_Start     (o_Start),
    .i_AxisDone  (i_AxisDone),
    .i_Abort     (i_Abort),
    .o_AxisAbort (o_AxisAbort),
    .o_Busy      (o_Busy),
    .o_MoveDone  (o_MoveDone),
    .o_Fault     (o_Fault),
    .i_ClearFault(i_ClearFault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] pack_ev(input int kind, input int c, input logic [3:0] v);
    return {20'd0, kind[7:0], c[31:0], v};
  endfunction

  task automatic push_ev(input int kind, input int c, input logic [3:0] v);
    exp_q.push_back(pack_ev(kind, c, v));
  endtask

  task automatic mon_ev(input int kind, input logic [3:0] v);
    logic [63:0] got;
    got = pack_ev(kind, cyc, v);
    if (exp_q.size() == 0) check("sb_unexpected", got, '1);
    else                   check("sb_event", got, exp_q.pop_front());
  endtask

  always @(negedge clk) begin
    if (o_Start != 4'b0000) mon_ev(EV_START, o_Start);
    if (o_MoveDone)         mon_ev(EV_DONE, 4'b0000);
    if (o_AxisAbort)        mon_ev(EV_ABORT, 4'b0000);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_status(input string tag, input logic r, input logic b, input logic f);
    @(negedge clk);
    check(tag, {61'd0, o_CmdReady, o_Busy, o_Fault}, {61'd0, r, b, f});
  endtask

  task automatic send_cmd(output int n, input logic [STEP_W-1:0] x, input logic [STEP_W-1:0] y,
                          input logic [STEP_W-1:0] z, input logic [STEP_W-1:0] e,
                          input logic [3:0] d);
    logic [3:0] mask;
    i_StepsX = x; i_StepsY = y; i_StepsZ = z; i_StepsE = e; i_Dir = d;
    i_CmdValid = 1'b1;
    n = cyc;
    mask = {e != '0, z != '0, y != '0, x != '0};
    if (mask != 4'b0000) push_ev(EV_START, n + 1, mask);
    else                 push_ev(EV_DONE, n + 1, 4'b0000);
    tick();
    i_CmdValid = 1'b0;
  endtask

  task automatic pulse_done(input logic [3:0] mask, input bit last);
    i_AxisDone = mask;
    if (last) push_ev(EV_DONE, cyc + 1, 4'b0000);
    tick();
    i_AxisDone = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;

    tick(3);
    i_Reset = 1'b0;
    check_status("reset_status", 1'b1, 1'b0, 1'b0);
    check("reset_steps", {o_StepsX, o_StepsY, o_StepsZ, o_StepsE}, 64'd0);
    check("reset_dir", {60'd0, o_Dir}, 64'd0);

    // Basic move: X, E, Y finish on separate cycles.
    send_cmd(n, 16'd100, 16'd50, 16'd0, 16'd20, 4'b0101);
    check_status("basic_launch", 1'b0, 1'b1, 1'b0);
    check("basic_lat_steps", {o_StepsX, o_StepsY, o_StepsZ, o_StepsE},
          {16'd100, 16'd50, 16'd0, 16'd20});
    check("basic_lat_dir", {60'd0, o_Dir}, 64'h5);
    tick();
    pulse_done(4'b0001, 1'b0);
    check_status("basic_wait1", 1'b0, 1'b1, 1'b0);
    tick();
    pulse_done(4'b1000, 1'b0);
    check_status("basic_wait2", 1'b0, 1'b1, 1'b0);
    pulse_done(4'b0010, 1'b1);
    check_status("basic_done", 1'b1, 1'b0, 1'b0);
    check("basic_hold_x", {48'd0, o_StepsX}, 64'd100);

    // Done pulses while idle are ignored.
    pulse_done(4'b1111, 1'b0);
    check_status("idle_spurious", 1'b1, 1'b0, 1'b0);

    // All-zero command completes in the launch cycle.
    send_cmd(n, 16'd0, 16'd0, 16'd0, 16'd0, 4'b1010);
    check_status("zero_launch", 1'b0, 1'b1, 1'b0);
    tick();
    check_status("zero_idle", 1'b1, 1'b0, 1'b0);

    // Simultaneous done on all four bits with only X/Y participating.
    send_cmd(n, 16'd7, 16'd9, 16'd0, 16'd0, 4'b0011);
    tick();
    pulse_done(4'b1111, 1'b1);
    check_status("simul_done", 1'b1, 1'b0, 1'b0);

    // Timeout: X never finishes.
    send_cmd(n, 16'd5, 16'd0, 16'd0, 16'd0, 4'b0001);
    push_ev(EV_ABORT, n + 18, 4'b0000);
    tick(16);
    check_status("tmo_last_wait", 1'b0, 1'b1, 1'b0);
    tick();
    check_status("tmo_fault", 1'b0, 1'b0, 1'b1);
    i_CmdValid = 1'b1;
    i_StepsX = 16'd77;
    i_Abort = 1'b1;
    i_AxisDone = 4'b1111;
    tick(2);
    i_CmdValid = 1'b0;
    i_Abort = 1'b0;
    i_AxisDone = 4'b0000;
    check_status("fault_hold", 1'b0, 1'b0, 1'b1);
    check("fault_lat_x", {48'd0, o_StepsX}, 64'd5);
    i_ClearFault = 1'b1;
    tick();
    i_ClearFault = 1'b0;
    check_status("fault_clear", 1'b1, 1'b0, 1'b0);

    // Done lands on the expiry cycle: done wins.
    send_cmd(n, 16'd5, 16'd0, 16'd0, 16'd0, 4'b0001);
    tick(16);
    pulse_done(4'b0001, 1'b1);
    check_status("tmo_race_done", 1'b1, 1'b0, 1'b0);

    // Abort together with the final done bit.
    send_cmd(n, 16'd3, 16'd4, 16'd0, 16'd0, 4'b0000);
    tick();
    pulse_done(4'b0001, 1'b0);
    i_AxisDone = 4'b0010;
    i_Abort = 1'b1;
    push_ev(EV_ABORT, cyc + 1, 4'b0000);
    tick();
    i_AxisDone = 4'b0000;
    i_Abort = 1'b0;
    check_status("abort_idle", 1'b1, 1'b0, 1'b0);

    // Abort while idle is ignored.
    i_Abort = 1'b1;
    tick();
    i_Abort = 1'b0;
    check_status("idle_abort", 1'b1, 1'b0, 1'b0);

    // Reset in WAIT aborts silently.
    send_cmd(n, 16'd8, 16'd0, 16'd0, 16'd0, 4'b1111);
    tick();
    i_Reset = 1'b1;
    tick();
    i_Reset = 1'b0;
    check_status("rst_mid_status", 1'b1, 1'b0, 1'b0);
    check("rst_mid_steps", {o_StepsX, o_StepsY, o_StepsZ, o_StepsE}, 64'd0);
    check("rst_mid_dir", {60'd0, o_Dir}, 64'd0);
    pulse_done(4'b0001, 1'b0);
    send_cmd(n, 16'd1, 16'd1, 16'd1, 16'hFFFF, 4'b0110);
    check("post_rst_e", {48'd0, o_StepsE}, 64'hFFFF);
    tick();
    pulse_done(4'b1111, 1'b1);
    check_status("post_rst_done", 1'b1, 1'b0, 1'b0);

    tick(3);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
